// File: rtl/vga_pkg.sv
// Shared types and default geometry for the framebuffer scanout/writer arbiter.
// Defaults describe a 640x480 4:4:4 RGB framebuffer.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int PIX_W_DEF    = 12;

    function automatic int fb_words(input int h_active, input int v_active);
        return h_active * v_active;
    endfunction

    localparam int FB_WORDS_DEF = H_ACTIVE_DEF * V_ACTIVE_DEF;
    localparam int ADDR_W_DEF   = $clog2(FB_WORDS_DEF);

    typedef enum logic [1:0] {
        ACC_NONE,
        ACC_FETCH,
        ACC_WRITE
    } acc_kind_e;

    typedef enum logic {
        IDLE,
        FETCH
    } fb_state_e;

endpackage

// File: rtl/vga_pix_fifo.sv
// Show-ahead pixel FIFO: the head entry is always visible on head_data.
// Supports push and pop in the same cycle; flush empties it in one cycle.
module vga_pix_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 12,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] entry_we;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !flush && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && !flush && (!full || do_pop);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_we
            assign entry_we[gi] = do_push && (wr_ptr_q == PTR_W'(gi));
        end
    endgenerate

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared on reset so the idle head reads as zero.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset) begin
                mem_q[i] <= '0;
            end else if (entry_we[i]) begin
                mem_q[i] <= push_data;
            end
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares a single-port framebuffer RAM between raster-order scanout prefetch
// and a pixel writer; scanout wins only when its FIFO reservation runs low.
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int PIX_W      = PIX_W_DEF,
    parameter int FIFO_DEPTH = 8,
    parameter int LOW_WM     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              pix_rd,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    output logic              underrun,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata
);

    localparam int FB_WORDS = fb_words(H_ACTIVE, V_ACTIVE);
    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int RES_W    = CNT_W + 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);
    localparam logic [ADDR_W:0]   FB_END    = (ADDR_W + 1)'(FB_WORDS);
    localparam logic [RES_W-1:0]  LOW_WM_R  = RES_W'(LOW_WM);
    localparam logic [RES_W-1:0]  DEPTH_R   = RES_W'(FIFO_DEPTH);

    fb_state_e         state_q, state_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic              inflight_q, inflight_d;
    logic              underrun_q, underrun_d;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_flush;
    logic              fifo_push;
    logic              fifo_pop;
    logic [RES_W-1:0]  reserved;
    logic              fetching;
    logic              urgent;
    logic              wr_in_range;
    acc_kind_e         acc;

    vga_pix_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIX_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (mem_rdata),
        .pop       (fifo_pop),
        .head_data (pix_data),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    // Counting the outstanding read guarantees its return always has a slot.
    assign reserved    = {1'b0, fifo_count} + RES_W'(inflight_q);
    assign fetching    = !reset && !frame_start && (state_q == FETCH);
    assign urgent      = fetching && (reserved < LOW_WM_R);
    assign wr_ready    = !reset && !urgent;
    assign wr_in_range = ({1'b0, wr_addr} < FB_END);
    assign pix_valid   = !fifo_empty;
    assign underrun    = underrun_q;

    always_comb begin
        acc = ACC_NONE;
        if (urgent) begin
            acc = ACC_FETCH;
        end else if (wr_valid && wr_ready) begin
            acc = ACC_WRITE;
        end else if (fetching && (reserved < DEPTH_R)) begin
            acc = ACC_FETCH;
        end
    end

    // Out-of-range writes still handshake but never reach the RAM.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (acc)
            ACC_FETCH: begin
                mem_en   = 1'b1;
                mem_addr = fetch_addr_q;
            end
            ACC_WRITE: begin
                if (wr_in_range) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = wr_addr;
                    mem_wdata = wr_data;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        inflight_d   = 1'b0;
        underrun_d   = underrun_q;
        fifo_flush   = frame_start;
        fifo_push    = inflight_q && !frame_start;
        fifo_pop     = pix_rd && pix_valid && !frame_start;
        if (frame_start) begin
            state_d      = FETCH;
            fetch_addr_d = '0;
            underrun_d   = 1'b0;
        end else begin
            if (acc == ACC_FETCH) begin
                inflight_d = 1'b1;
                if (fetch_addr_q == LAST_ADDR) begin
                    state_d      = IDLE;
                    fetch_addr_d = '0;
                end else begin
                    fetch_addr_d = fetch_addr_q + ADDR_W'(1);
                end
            end
            if (pix_rd && !pix_valid) begin
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            fetch_addr_q <= '0;
            inflight_q   <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            inflight_q   <= inflight_d;
            underrun_q   <= underrun_d;
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter on a 8x2 framebuffer with pixel(i)=i.
// Expected pixels are queued at frame_start and checked as the display pops them.
module tb_vga_fb_arbiter;
    import vga_pkg::*;

    localparam int H     = 8;
    localparam int V     = 2;
    localparam int FB    = H * V;
    localparam int AW    = 19;
    localparam int PW    = 12;
    localparam int DEPTH = 8;
    localparam int LWM   = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_start;
    logic          pix_rd;
    logic [PW-1:0] pix_data;
    logic          pix_valid;
    logic          underrun;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [PW-1:0] wr_data;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [PW-1:0] mem_wdata;
    logic [PW-1:0] mem_rdata;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [PW-1:0] fb_ram  [FB];
    logic [PW-1:0] ref_img [FB];
    logic [PW-1:0] sb [$];
    bit            active;
    int            fetched;
    int            popped;

    vga_fb_arbiter #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .ADDR_W     (AW),
        .PIX_W      (PW),
        .FIFO_DEPTH (DEPTH),
        .LOW_WM     (LWM)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .pix_rd      (pix_rd),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .underrun    (underrun),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Framebuffer RAM: one-cycle read latency, preloaded while reset is held.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FB; i++) fb_ram[i] <= PW'(i);
            mem_rdata <= '0;
        end else if (mem_en && (mem_addr < AW'(FB))) begin
            if (mem_we) fb_ram[mem_addr[3:0]] <= mem_wdata;
            else        mem_rdata <= fb_ram[mem_addr[3:0]];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle(input bit rst, input bit fs, input bit rd, input bit wv,
                         input logic [AW-1:0] wa, input logic [PW-1:0] wd);
        bit            urg;
        bit            exp_ready;
        bit            exp_write;
        bit            exp_fetch;
        bit            do_pop;
        int            res;
        logic [PW-1:0] e;
        @(negedge clk);
        reset       = rst;
        frame_start = fs;
        pix_rd      = rd;
        wr_valid    = wv;
        wr_addr     = wa;
        wr_data     = wd;
        #1;
        res       = fetched - popped;
        urg       = !rst && !fs && active && (fetched < FB) && (res < LWM);
        exp_ready = !rst && !urg;
        exp_write = wv && exp_ready;
        exp_fetch = urg || (!rst && !fs && active && (fetched < FB) && !wv && (res < DEPTH));
        chk("wr_ready", wr_ready, exp_ready);
        chk("fetch_en", mem_en && !mem_we, exp_fetch);
        if (exp_fetch) chk("fetch_addr", mem_addr, fetched);
        if (exp_write) begin
            if (wa < AW'(FB)) begin
                chk("wr_bus", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, wa, wd});
                ref_img[wa[3:0]] = wd;
                $display("write addr=%0d data=0x%03h", wa, wd);
            end else begin
                chk("wr_drop", mem_en, 0);
                $display("write addr=%0d dropped", wa);
            end
        end
        do_pop = !rst && !fs && rd && pix_valid;
        if (do_pop) begin
            chk("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pix_data", pix_data, e);
                $display("pop pix=0x%03h exp=0x%03h", pix_data, e);
            end
            popped++;
        end
        if (rst) begin
            active = 0; fetched = 0; popped = 0;
            sb.delete();
        end else if (fs) begin
            active = 1; fetched = 0; popped = 0;
            sb.delete();
            for (int i = 0; i < FB; i++) sb.push_back(ref_img[i]);
        end else if (exp_fetch) begin
            fetched++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, '0, '0);
    endtask

    initial begin
        reset = 1'b1; frame_start = 1'b0; pix_rd = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        active = 0; fetched = 0; popped = 0;
        for (int i = 0; i < FB; i++) ref_img[i] = PW'(i);

        // Reset state, with a writer knocking during reset.
        cycle(1, 0, 0, 1, AW'(5), 12'h111);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_data", pix_data, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        cycle(1, 0, 0, 0, '0, '0);

        // Read on the first cycle after reset: sticky underrun.
        cycle(0, 0, 1, 0, '0, '0);
        cycle(0, 0, 0, 0, '0, '0);
        chk("underrun_set", underrun, 1);
        chk("underrun_pix_data", pix_data, 0);

        // No frame yet: idle bus, then direct writes.
        idle(4);
        chk("idle_pix_valid", pix_valid, 0);
        cycle(0, 0, 0, 1, AW'(3), 12'hABC);
        chk("t1_mem_we", mem_we, 1);
        chk("t1_mem_addr", mem_addr, 3);
        cycle(0, 0, 0, 1, AW'(3), 12'h003);
        cycle(0, 0, 0, 1, AW'(16), 12'h555);
        idle(1);
        chk("underrun_held", underrun, 1);
        chk("ram3_restored", fb_ram[3], 12'h003);

        // Frame with no reads: fill the FIFO then stop fetching.
        cycle(0, 1, 0, 0, '0, '0);
        for (int k = 0; k < 12; k++) begin
            cycle(0, 0, 0, 0, '0, '0);
            if (k == 0) chk("underrun_cleared", underrun, 0);
        end
        chk("full_pix_valid", pix_valid, 1);
        chk("full_pix_data", pix_data, 12'h000);

        // Full frame drained at one pixel every 4 cycles.
        cycle(0, 1, 0, 0, '0, '0);
        for (int k = 0; k < 64; k++) cycle(0, 0, (k % 4) == 3, 0, '0, '0);
        idle(1);
        chk("t3_state_idle", 64'(dut.state_q), 64'(IDLE));
        chk("t3_underrun", underrun, 0);
        chk("t3_pix_valid", pix_valid, 0);
        chk("t3_sb_left", sb.size(), 0);

        // Writer held high for the whole frame.
        cycle(0, 1, 0, 1, AW'(0), ref_img[0]);
        for (int k = 0; k < 64; k++) begin
            int a;
            a = (k + 1) % FB;
            cycle(0, 0, (k % 4) == 3, 1, AW'(a), ref_img[a]);
        end
        idle(1);
        chk("t4_underrun", underrun, 0);
        chk("t4_sb_left", sb.size(), 0);

        // Restart mid-frame right after a fetch was issued.
        cycle(0, 1, 0, 0, '0, '0);
        for (int k = 0; k < 15; k++) cycle(0, 0, (k >= 3) && (k <= 13) && (k % 2 == 1), 0, '0, '0);
        chk("t6_popped", popped, 6);
        cycle(0, 1, 1, 0, '0, '0);
        for (int k = 0; k < 64; k++) cycle(0, 0, (k % 4) == 3, 0, '0, '0);
        idle(1);
        chk("t6_underrun", underrun, 0);
        chk("t6_sb_left", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
